fetch_queue_stage: RTL and testbench
====================================

Name: fetch_queue_stage

Overview:
- Parametrised successor to the single-cycle fetch stage. Decouples PC generation from instruction memory, which now has variable latency, using a valid/ready request port, an in-order response port, and a prefetch FIFO.
- Sits between the PC/branch logic (redirect from Execute) and the IF/ID register.
- Hides memory latency, absorbs decode stalls, and squashes wrong-path fetches on redirect.

Parameters:
XLEN, 32, width of PC and instruction words.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FIFO_DEPTH, 4, prefetch FIFO entries (power of two, >=2).
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests (>=1).

Ports:
i_Clk  in  1  clock, rising edge.
i_Reset_n  in  1  asynchronous reset, active-low.
i_PCSrcE  in  1  redirect request from Execute.
i_PCTargetE  in  XLEN  redirect target.
i_StallF  in  1  decode not ready; hold the output entry.
o_ImemReqValid  out  1  fetch request valid.
o_ImemReqAddr  out  XLEN  fetch address (word aligned).
i_ImemReqReady  in  1  memory accepts the request.
i_ImemRspValid  in  1  response valid (in order, no backpressure).
i_ImemRspData  in  XLEN  instruction word.
o_ValidF  out  1  output entry valid.
o_InstrF  out  XLEN  instruction at the FIFO head.
o_PCF  out  XLEN  PC of the head instruction.
o_PCPlus4F  out  XLEN  o_PCF + 4, modulo 2^XLEN.

Behaviour:
- Reset (async assert, sync-safe deassert) sets the following:
  - fetch PC = RESET_PC
  - FIFO empty
  - outstanding = 0, drop count = 0
  - o_ValidF = 0, o_ImemReqValid = 0
  - o_InstrF, o_PCF, o_PCPlus4F = 0
- Reset mid-operation discards all state. Imem is reset by the same signal, so no stale responses arrive afterwards.
- Request rule: o_ImemReqValid = !i_PCSrcE && (outstanding < MAX_OUTSTANDING) && (fifo_count + outstanding < FIFO_DEPTH).
  - This credit check guarantees every response has a FIFO slot.
- o_ImemReqAddr = fetch PC.
- Handshake: when valid && ready, the request is accepted:
  - fetch PC += 4 (wraps at 2^XLEN)
  - the address is pushed into the in-flight PC queue (depth MAX_OUTSTANDING)
  - outstanding++
- Response:
  - Each i_ImemRspValid pops the in-flight PC queue and decrements outstanding.
  - If drop count > 0: data discarded, drop count--.
  - Otherwise: {instr, pc} pushed to the FIFO.
- Acceptance and response in the same cycle leave outstanding unchanged.
- Output: o_ValidF = FIFO not empty; o_InstrF/o_PCF come from the head entry.
  - Head pops when o_ValidF && !i_StallF.
  - With i_StallF=1 all outputs hold.
- Minimum latency: request accepted cycle N; response no earlier than N+1; o_ValidF visible cycle N+2.
- Redirect (i_PCSrcE=1), taking priority over stall and response:
  - FIFO flushed; o_ValidF = 0 next cycle.
  - fetch PC <= {i_PCTargetE[XLEN-1:2], 2'b00}.
  - No request issued this cycle.
  - drop count <= outstanding minus (1 if a response arrives this cycle); that response is itself discarded.
  - In-flight PC queue is drained by the dropped responses, not cleared.
- Back-to-back redirects: each recomputes drop count from the current outstanding; the last target wins.
- FIFO full: no requests issue (credit rule); a pop and push in the same cycle are both allowed.
- Sustained throughput: 1 instr/cycle when memory ready/response every cycle and i_StallF=0.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs o_FetchCount (32b) and o_SquashCount (32b), both reset to 0, saturating.
  - o_FetchCount +1 per accepted request.
  - o_SquashCount increments by the number of entries flushed from the FIFO plus 1 per dropped response.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, memory always ready, 1-cycle latency, RESET_PC=0 -> requests 0x0,0x4,0x8...; o_ValidF=1 from cycle 2; o_PCF 0x0,0x4,... one per cycle; o_PCPlus4F=0x4,0x8.
- Hold i_StallF=1 for 10 cycles -> o_PCF frozen at the same value; outstanding+fifo_count never exceeds 4; no response is lost; stream resumes in order on release.
- Redirect to 0x100 with 2 requests outstanding -> next 2 responses discarded; next o_PCF=0x100; instructions 0x100,0x104 delivered; no wrong-path instruction is ever valid.
- Redirect coincident with a response and i_StallF=1 -> response dropped, FIFO empty next cycle, o_ImemReqValid=0 that cycle, fetch resumes at target.
- Target 0x203 -> o_ImemReqAddr=0x200; fetch PC 0xFFFF_FFFC -> next request 0x0000_0000 and o_PCPlus4F=0x0.
- Assert i_Reset_n low mid-stream with 2 outstanding -> all outputs 0 immediately (async); after release, fetch restarts at RESET_PC; FETCH_PERF_CNT_EN counters read 0.

Source files
------------

// File: rtl/fetch_queue_stage.sv
// Fetch stage: PC generation, variable-latency imem port, prefetch FIFO.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/squash counters.
module fetch_queue_stage #(
    parameter int unsigned     XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH      = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            i_Clk,
    input  logic            i_Reset_n,
    input  logic            i_PCSrcE,
    input  logic [XLEN-1:0] i_PCTargetE,
    input  logic            i_StallF,
    output logic            o_ImemReqValid,
    output logic [XLEN-1:0] o_ImemReqAddr,
    input  logic            i_ImemReqReady,
    input  logic            i_ImemRspValid,
    input  logic [XLEN-1:0] i_ImemRspData,
    output logic            o_ValidF,
    output logic [XLEN-1:0] o_InstrF,
    output logic [XLEN-1:0] o_PCF,
    output logic [XLEN-1:0] o_PCPlus4F
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     o_FetchCount,
    output logic [31:0]     o_SquashCount
`endif
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned IW =
        (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

    localparam logic [IW-1:0] IF_LAST = IW'(MAX_OUTSTANDING - 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] CREDIT  = SW'(FIFO_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;

    logic [XLEN-1:0] fifo_instr_q [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc_q    [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [XLEN-1:0] ifq_q [MAX_OUTSTANDING];
    logic [IW-1:0]   ifw_q, ifw_d;
    logic [IW-1:0]   ifr_q, ifr_d;
    logic [OW-1:0]   out_q, out_d;
    logic [OW-1:0]   drop_q, drop_d;

    logic            redirect;
    logic            req_valid;
    logic            accept;
    logic            rsp;
    logic            drop_rsp;
    logic            push;
    logic            pop;
    logic            head_valid;
    logic [SW-1:0]   used;
    logic [XLEN-1:0] rsp_pc;

    assign redirect   = i_PCSrcE;
    assign head_valid = (count_q != '0);
    assign used       = SW'(count_q) + SW'(out_q);

    // Credit check: every accepted request is guaranteed a FIFO slot.
    assign req_valid = i_Reset_n && !redirect &&
                       (out_q < OUT_MAX) && (used < CREDIT);
    assign accept    = req_valid && i_ImemReqReady;
    assign rsp       = i_ImemRspValid;
    assign drop_rsp  = rsp && (redirect || (drop_q != '0));
    assign push      = rsp && !drop_rsp;
    assign pop       = head_valid && !i_StallF && !redirect;
    assign rsp_pc    = ifq_q[ifr_q];

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = {i_PCTargetE[XLEN-1:2], 2'b00};
        end else if (accept) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_comb begin
        ifw_d = ifw_q;
        ifr_d = ifr_q;
        out_d = out_q;
        if (accept) begin
            ifw_d = (ifw_q == IF_LAST) ? '0 : ifw_q + IW'(1);
        end
        if (rsp) begin
            ifr_d = (ifr_q == IF_LAST) ? '0 : ifr_q + IW'(1);
        end
        unique case ({accept, rsp})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase
    end

    // In-flight queue is not cleared on redirect; dropped responses drain it.
    always_comb begin
        drop_d = drop_q;
        if (redirect) begin
            drop_d = rsp ? out_q - OW'(1) : out_q;
        end else if (drop_rsp) begin
            drop_d = drop_q - OW'(1);
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (redirect) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            pc_q    <= RESET_PC;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ifw_q   <= '0;
            ifr_q   <= '0;
            out_q   <= '0;
            drop_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ifw_q   <= ifw_d;
            ifr_q   <= ifr_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else if (push) begin
            fifo_instr_q[wptr_q] <= i_ImemRspData;
            fifo_pc_q[wptr_q]    <= rsp_pc;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                ifq_q[i] <= '0;
            end
        end else if (accept) begin
            ifq_q[ifw_q] <= pc_q;
        end
    end

    assign o_ImemReqValid = req_valid;
    assign o_ImemReqAddr  = pc_q;
    assign o_ValidF       = head_valid;
    assign o_InstrF       = head_valid ? fifo_instr_q[rptr_q] : '0;
    assign o_PCF          = head_valid ? fifo_pc_q[rptr_q] : '0;
    assign o_PCPlus4F     = head_valid ? fifo_pc_q[rptr_q] + XLEN'(4) : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] squash_cnt_q, squash_cnt_d;
    logic [32:0] squash_sum;

    assign squash_sum = {1'b0, squash_cnt_q} +
                        (redirect ? 33'(count_q) : 33'd0) +
                        (drop_rsp ? 33'd1 : 33'd0);

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        squash_cnt_d = squash_sum[32] ? '1 : squash_sum[31:0];
        if (accept && (fetch_cnt_q != '1)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            fetch_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign o_FetchCount  = fetch_cnt_q;
    assign o_SquashCount = squash_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage with imem model and scoreboard.
// Expected fetch stream is pushed on request accept, popped on delivery.
module tb_fetch_queue_stage;

    logic        clk;
    logic        rst_n;
    logic        pcsrc;
    logic [31:0] tgt;
    logic        stall;
    logic        req_v;
    logic [31:0] req_a;
    logic        req_r;
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pcf;
    logic [31:0] pcp4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fcnt;
    logic [31:0] scnt;
`endif

    fetch_queue_stage dut (
        .i_Clk          (clk),
        .i_Reset_n      (rst_n),
        .i_PCSrcE       (pcsrc),
        .i_PCTargetE    (tgt),
        .i_StallF       (stall),
        .o_ImemReqValid (req_v),
        .o_ImemReqAddr  (req_a),
        .i_ImemReqReady (req_r),
        .i_ImemRspValid (rsp_v),
        .i_ImemRspData  (rsp_d),
        .o_ValidF       (valid),
        .o_InstrF       (instr),
        .o_PCF          (pcf),
        .o_PCPlus4F     (pcp4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_FetchCount   (fcnt),
        .o_SquashCount  (scnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mem_q [$];
    logic [31:0] sb_q  [$];
    logic [31:0] model_pc;
    logic [31:0] held;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic s, input logic r, input logic [31:0] t,
                        input logic rdy, input logic rok);
        logic [31:0] e;
        stall = s;
        pcsrc = r;
        tgt   = t;
        req_r = rdy;
        if (rok && mem_q.size() > 0) begin
            rsp_v = 1'b1;
            rsp_d = mem_word(mem_q.pop_front());
        end else begin
            rsp_v = 1'b0;
            rsp_d = 32'h0;
        end
        #1;
        if (valid && !s && !r) begin
            n_vec++;
            assert (sb_q.size() != 0) else begin
                n_err++;
                $error("FAIL spurious_deliver observed=%h expected=none",
                       pcf);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("deliver_pc", pcf, e);
                chk("deliver_instr", instr, mem_word(e));
                chk("deliver_pcp4", pcp4, e + 32'd4);
            end
        end
        if (req_v && rdy) begin
            chk("req_addr", req_a, model_pc);
            mem_q.push_back(req_a);
            sb_q.push_back(req_a);
            model_pc = model_pc + 32'd4;
        end
        if (r) begin
            chk("redir_no_req", {31'd0, req_v}, 32'd0);
            sb_q.delete();
            model_pc = {t[31:2], 2'b00};
        end
        chk("credit", {31'd0, sb_q.size() <= 4}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!valid && n < 20) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            n++;
        end
        chk(tag, {31'd0, valid}, 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
        chk({tag, "_reqv"}, {31'd0, req_v}, 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_pc"}, pcf, 32'd0);
        chk({tag, "_pcp4"}, pcp4, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, "_fcnt"}, fcnt, 32'd0);
        chk({tag, "_scnt"}, scnt, 32'd0);
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        pcsrc    = 1'b0;
        tgt      = 32'h0;
        stall    = 1'b0;
        req_r    = 1'b1;
        rsp_v    = 1'b0;
        rsp_d    = 32'h0;
        model_pc = 32'h0;
        #1;
        chk_reset("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("reset_addr", req_a, 32'h0);

        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("valid_c1", {31'd0, valid}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("valid_c2", {31'd0, valid}, 32'd1);
        chk("first_pc", pcf, 32'h0);
        chk("first_pcp4", pcp4, 32'h4);
        run(8);

        held = pcf;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            chk("stall_hold", pcf, held);
            chk("stall_valid", {31'd0, valid}, 32'd1);
        end
        run(10);

        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("two_outstanding", mem_q.size(), 32'd2);
        step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
        chk("redir_flush", {31'd0, valid}, 32'd0);
        wait_valid("redir_wait");
        chk("redir_pc0", pcf, 32'h100);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("redir_pc1", pcf, 32'h104);
        run(4);

        step(1'b1, 1'b1, 32'h203, 1'b1, 1'b1);
        chk("coinc_flush", {31'd0, valid}, 32'd0);
        chk("align_addr", req_a, 32'h200);
        wait_valid("coinc_wait");
        chk("coinc_pc", pcf, 32'h200);
        run(3);

        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        wait_valid("wrap_wait");
        chk("wrap_pc", pcf, 32'hFFFF_FFFC);
        chk("wrap_pcp4", pcp4, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap_next", pcf, 32'h0);
        run(3);
`ifdef FETCH_PERF_CNT_EN
        chk("fcnt_nz", {31'd0, fcnt != 0}, 32'd1);
        chk("scnt_nz", {31'd0, scnt != 0}, 32'd1);
`endif

        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("rst_two_out", mem_q.size(), 32'd2);
        rsp_v = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        mem_q.delete();
        sb_q.delete();
        model_pc = 32'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("restart_addr", req_a, 32'h0);
        run(2);
        chk("restart_pc", pcf, 32'h0);
        run(6);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        end
        chk("drain", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
